rv_plic_serial_arbiter: RTL and testbench

- Time-multiplexed replacement for the combinational per-target priority tree in the PLIC.
- Sweeps the interrupt sources one per cycle and tracks the best candidate (pending, enabled, above threshold, highest priority).
- Publishes the winner as irq_o/irq_id_o at the end of each sweep.
- One instance per target; sits between the gateway (ip), the register block (ie, prio, threshold) and the target claim/complete path. It trades notification latency for area when NumSrc is large.

---
 rtl/rv_plic_serial_arbiter.sv | 114 +++++++++++
 tb/tb_rv_plic_serial_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_plic_serial_arbiter.sv
// Serial per-target PLIC arbiter: sweeps sources 1..N_SOURCE-1, one per cycle.
// It tracks the best candidate and publishes it as irq_o/irq_id_o at the end of each sweep.
// Latency: N_SOURCE-1 cycles per sweep. The worst-case ip-to-irq_o latency is 2*(N_SOURCE-1) cycles.
// Ports: clk_i/rst_ni clock and async active-low reset; en_i enable (0 forces IDLE);
//   ip_i/ie_i pending and enable bits; prio_i packed priorities, PRIOW bits per source;
//   threshold_i target threshold; claim_i CC read pulse;
//   irq_o/irq_id_o registered notification and winning ID (0 = none);
//   sweep_done_o one-cycle pulse on each commit.
module rv_plic_serial_arbiter #(
  parameter int N_SOURCE = 49,
  parameter int MAX_PRIO = 3,
  localparam int SRCW = $clog2(N_SOURCE),
  localparam int PRIOW = $clog2(MAX_PRIO + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [N_SOURCE-1:0]       ip_i,
  input  logic [N_SOURCE-1:0]       ie_i,
  input  logic [N_SOURCE*PRIOW-1:0] prio_i,
  input  logic [PRIOW-1:0]          threshold_i,
  input  logic                      claim_i,
  output logic                      irq_o,
  output logic [SRCW-1:0]           irq_id_o,
  output logic                      sweep_done_o
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [SRCW-1:0] FIRST_IDX = SRCW'(1);
  localparam logic [SRCW-1:0] LAST_IDX  = SRCW'(N_SOURCE - 1);

  state_t           state;
  logic [SRCW-1:0]  idx;
  logic [SRCW-1:0]  best_id;
  logic [PRIOW-1:0] best_prio;

  logic [PRIOW-1:0] prio_arr [N_SOURCE];
  logic [PRIOW-1:0] cur_prio;
  logic             qualify;
  logic [SRCW-1:0]  cand_id;
  logic [PRIOW-1:0] cand_prio;
  logic             stale;

  always_comb begin
    for (int s = 0; s < N_SOURCE; s++) begin
      prio_arr[s] = prio_i[s*PRIOW +: PRIOW];
    end
  end

  // The strict compare against best_prio keeps the earlier (lower) ID on ties.
  // A zero priority can never beat the threshold, so it never qualifies.
  always_comb begin
    cur_prio  = prio_arr[idx];
    qualify   = ip_i[idx] & ie_i[idx] & (cur_prio > threshold_i) & (cur_prio > best_prio);
    cand_id   = qualify ? idx : best_id;
    cand_prio = qualify ? cur_prio : best_prio;
  end

  // The published winner lost its pending or enable bit since the last commit.
  assign stale = irq_o & ~(ip_i[irq_id_o] & ie_i[irq_id_o]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      idx          <= FIRST_IDX;
      best_id      <= '0;
      best_prio    <= '0;
      irq_o        <= 1'b0;
      irq_id_o     <= '0;
      sweep_done_o <= 1'b0;
    end else begin
      sweep_done_o <= 1'b0;
      if (!en_i) begin
        state     <= IDLE;
        idx       <= FIRST_IDX;
        best_id   <= '0;
        best_prio <= '0;
        irq_o     <= 1'b0;
        irq_id_o  <= '0;
      end else if (state == IDLE) begin
        // Outputs are already clear in IDLE; start a fresh sweep.
        state     <= SCAN;
        idx       <= FIRST_IDX;
        best_id   <= '0;
        best_prio <= '0;
      end else if (claim_i) begin
        // Restart so the ID being claimed is not re-presented from stale sweep data.
        idx       <= FIRST_IDX;
        best_id   <= '0;
        best_prio <= '0;
        irq_o     <= 1'b0;
        irq_id_o  <= '0;
      end else if (idx == LAST_IDX) begin
        // Commit: the result includes the source evaluated in this final cycle.
        irq_o        <= (cand_id != '0);
        irq_id_o     <= cand_id;
        sweep_done_o <= 1'b1;
        idx          <= FIRST_IDX;
        best_id      <= '0;
        best_prio    <= '0;
      end else begin
        idx       <= idx + 1'b1;
        best_id   <= cand_id;
        best_prio <= cand_prio;
        if (stale) begin
          irq_o    <= 1'b0;
          irq_id_o <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_plic_serial_arbiter.sv
// Testbench for rv_plic_serial_arbiter with N_SOURCE=8 and MAX_PRIO=3.
// It runs directed scenarios, then a randomized phase.
// Every cycle is compared against a sweep-level reference model.
module tb_rv_plic_serial_arbiter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  ip;
  logic [7:0]  ie;
  logic [1:0]  src_prio [8];
  logic [15:0] prio;
  logic [1:0]  threshold;
  logic        claim;
  logic        irq;
  logic [2:0]  irq_id;
  logic        sweep_done;

  int total = 0;
  int bad   = 0;

  rv_plic_serial_arbiter #(.N_SOURCE(8), .MAX_PRIO(3)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .ip_i         (ip),
    .ie_i         (ie),
    .prio_i       (prio),
    .threshold_i  (threshold),
    .claim_i      (claim),
    .irq_o        (irq),
    .irq_id_o     (irq_id),
    .sweep_done_o (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int s = 0; s < 8; s++) prio[s*2 +: 2] = src_prio[s];
  end

  // Reference model. Each source gets an "effective priority", recorded at its own evaluation cycle.
  // The effective priority is 0 when the source would not qualify.
  // At commit, the winner is the lowest ID holding the maximum recorded value.
  logic       m_active;
  int         m_pos;
  int         rec [8];
  logic       m_irq;
  logic [2:0] m_id;
  logic       m_done;

  function automatic int eff(input int s);
    int p;
    p = int'(src_prio[s]);
    if (ip[s] && ie[s] && p > int'(threshold)) return p;
    return 0;
  endfunction

  function automatic int winner(input int cur_pos);
    int vals [8];
    int top;
    top = 0;
    for (int s = 1; s < 8; s++) begin
      vals[s] = (s == cur_pos) ? eff(s) : rec[s];
      if (vals[s] > top) top = vals[s];
    end
    if (top == 0) return 0;
    for (int s = 1; s < 8; s++) if (vals[s] == top) return s;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_pos    <= 1;
      m_irq    <= 1'b0;
      m_id     <= 3'd0;
      m_done   <= 1'b0;
      for (int s = 0; s < 8; s++) rec[s] <= 0;
    end else begin
      m_done <= 1'b0;
      if (!en) begin
        m_active <= 1'b0;
        m_pos    <= 1;
        m_irq    <= 1'b0;
        m_id     <= 3'd0;
        for (int s = 0; s < 8; s++) rec[s] <= 0;
      end else if (!m_active) begin
        m_active <= 1'b1;
        m_pos    <= 1;
        for (int s = 0; s < 8; s++) rec[s] <= 0;
      end else if (claim) begin
        m_pos <= 1;
        m_irq <= 1'b0;
        m_id  <= 3'd0;
        for (int s = 0; s < 8; s++) rec[s] <= 0;
      end else if (m_pos == 7) begin
        m_irq  <= (winner(7) != 0);
        m_id   <= 3'(winner(7));
        m_done <= 1'b1;
        m_pos  <= 1;
        for (int s = 0; s < 8; s++) rec[s] <= 0;
      end else begin
        rec[m_pos] <= eff(m_pos);
        m_pos      <= m_pos + 1;
        if (m_irq && !(ip[m_id] && ie[m_id])) begin
          m_irq <= 1'b0;
          m_id  <= 3'd0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("irq_o", {31'd0, irq}, {31'd0, m_irq});
    chk("irq_id_o", {29'd0, irq_id}, {29'd0, m_id});
    chk("sweep_done_o", {31'd0, sweep_done}, {31'd0, m_done});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_all();
    end
  endtask

  // Advance until a commit pulse has been observed, bounded by a cycle budget.
  task automatic wait_done();
    int k;
    logic seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      chk_all();
      k++;
      seen = sweep_done;
    end
    chk("commit_seen", {31'd0, seen}, 32'd1);
  endtask

  // Called just after the IDLE->SCAN edge; counts edges to the first commit.
  task automatic measure_latency();
    int cnt;
    logic seen;
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      chk_all();
      cnt++;
      seen = sweep_done;
    end
    chk("first_commit_latency", cnt, 32'd7);
  endtask

  task automatic clear_srcs();
    ip = 8'd0;
    ie = 8'd0;
    for (int s = 0; s < 8; s++) src_prio[s] = 2'd0;
  endtask

  task automatic set_src(input int s, input logic [1:0] p);
    ip[s] = 1'b1;
    ie[s] = 1'b1;
    src_prio[s] = p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    claim = 1'b0;
    threshold = 2'd0;
    clear_srcs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_id", {29'd0, irq_id}, 32'd0);
    chk("reset_done", {31'd0, sweep_done}, 32'd0);
    run(2);

    // Single source 5 at priority 2.
    set_src(5, 2'd2);
    en = 1'b1;
    wait_done();
    chk("single_irq", {31'd0, irq}, 32'd1);
    chk("single_id", {29'd0, irq_id}, 32'd5);

    // Reserved source 0 never wins.
    clear_srcs();
    set_src(0, 2'd3);
    wait_done();
    wait_done();
    chk("src0_irq", {31'd0, irq}, 32'd0);
    chk("src0_id", {29'd0, irq_id}, 32'd0);

    // Tie goes to the lower ID; a raised priority then takes over.
    clear_srcs();
    set_src(3, 2'd2);
    set_src(6, 2'd2);
    wait_done();
    wait_done();
    chk("tie_id", {29'd0, irq_id}, 32'd3);
    src_prio[6] = 2'd3;
    wait_done();
    chk("raise_id", {29'd0, irq_id}, 32'd6);

    // Threshold equal to the priority blocks the source; lowering it admits the source.
    clear_srcs();
    set_src(5, 2'd2);
    threshold = 2'd2;
    wait_done();
    wait_done();
    chk("thr_block_irq", {31'd0, irq}, 32'd0);
    threshold = 2'd1;
    wait_done();
    chk("thr_pass_irq", {31'd0, irq}, 32'd1);
    chk("thr_pass_id", {29'd0, irq_id}, 32'd5);

    // Claim clears the outputs, and nothing is re-presented once ip is cleared.
    claim = 1'b1;
    ip[5] = 1'b0;
    run(1);
    claim = 1'b0;
    chk("claim_irq", {31'd0, irq}, 32'd0);
    chk("claim_id", {29'd0, irq_id}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      wait_done();
      chk("post_claim_irq", {31'd0, irq}, 32'd0);
    end

    // Claim on the commit edge overrides the commit.
    ip[5] = 1'b1;
    wait_done();
    chk("pre_claim_id", {29'd0, irq_id}, 32'd5);
    run(6);
    claim = 1'b1;
    run(1);
    claim = 1'b0;
    chk("claim_commit_irq", {31'd0, irq}, 32'd0);
    chk("claim_commit_id", {29'd0, irq_id}, 32'd0);
    chk("claim_commit_done", {31'd0, sweep_done}, 32'd0);

    // Stale drop when the enable bit of the winner is removed.
    threshold = 2'd0;
    clear_srcs();
    set_src(4, 2'd1);
    wait_done();
    wait_done();
    chk("stale_pre_id", {29'd0, irq_id}, 32'd4);
    ie[4] = 1'b0;
    run(1);
    chk("stale_irq", {31'd0, irq}, 32'd0);
    chk("stale_id", {29'd0, irq_id}, 32'd0);

    // Enable drop forces IDLE; re-enabling restarts the sweep from idx 1.
    ie[4] = 1'b1;
    wait_done();
    chk("en_pre_irq", {31'd0, irq}, 32'd1);
    en = 1'b0;
    run(1);
    chk("en_drop_irq", {31'd0, irq}, 32'd0);
    chk("en_drop_id", {29'd0, irq_id}, 32'd0);
    run(3);
    en = 1'b1;
    run(1);
    measure_latency();
    chk("en_restart_id", {29'd0, irq_id}, 32'd4);

    // Asynchronous reset in the middle of a sweep with irq asserted.
    run(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_id", {29'd0, irq_id}, 32'd0);
    chk("arst_done", {31'd0, sweep_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1);
    measure_latency();
    chk("arst_restart_id", {29'd0, irq_id}, 32'd4);

    // Randomized phase: slow-moving sources, occasional claims and enable drops.
    ip = 8'($urandom);
    ie = 8'($urandom);
    for (int s = 0; s < 8; s++) src_prio[s] = 2'($urandom_range(0, 3));
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      chk_all();
      if ($urandom_range(0, 7) == 0) ip = ip ^ (8'd1 << $urandom_range(0, 7));
      if ($urandom_range(0, 11) == 0) ie = ie ^ (8'd1 << $urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) src_prio[$urandom_range(0, 7)] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) threshold = 2'($urandom_range(0, 2));
      en = ($urandom_range(0, 59) != 0);
      claim = ($urandom_range(0, 29) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
